// File: rtl/tiled_ctrl_pkg.sv
// tiled_ctrl_pkg
// Shared definitions for the tiled layer controller: the FSM state
// encoding, the default parameter values and helper functions that
// derive the per-phase beat counts from the vector width and GLB lane count.
package tiled_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_IFMAP  = 3'd1,
        LOAD_WEIGHT = 3'd2,
        LOAD_BIAS   = 3'd3,
        ARRAY       = 3'd4,
        PPU         = 3'd5,
        DONE        = 3'd6
    } ctrl_state_e;

    localparam int DEF_WIDTH       = 64;
    localparam int DEF_LANES       = 4;
    localparam int DEF_ARRAY_TIMES = 16;
    localparam int DEF_MAX_TILES   = 16;

    // One ifmap row packed LANES elements per GLB word.
    function automatic int ifmap_beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    // Full WIDTH x WIDTH weight matrix packed LANES elements per GLB word.
    function automatic int weight_beats(input int width, input int lanes);
        return (width * width) / lanes;
    endfunction

    // One bias word per output channel.
    function automatic int bias_beats(input int width);
        return width;
    endfunction

    // One PPU beat per output element of the row.
    function automatic int ppu_beats(input int width);
        return width;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// beat_counter
// Small up-counter shared by the controller for the GLB address, the array
// pass index and the PPU beat count.
// Ports:
//   clk, rst     clock and asynchronous active-low reset
//   clear        synchronous clear to zero (highest priority)
//   load         synchronous load of load_value
//   load_value   value taken when load is high
//   enable       count up by one
//   terminal     value at which at_terminal is flagged
//   count        current count
//   at_terminal  high while count equals terminal
module beat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         at_terminal
);

    // Clear wins over load, load wins over counting, so a phase exit on the
    // same edge as a final beat always leaves the counter at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/tiled_layer_controller.sv
// tiled_layer_controller
// Sequences one layer as a run of tiles. Each tile loads ifmap, weight and
// bias words from DRAM into the GLB (one word per accepted DRAM beat), runs
// ARRAY_TIMES systolic-array passes and then drains the result through the
// PPU. Weight/bias loading can be restricted to tile 0 when the job reuses
// them across tiles.
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   start, cfg_tiles,
//   cfg_reuse_weight          job request and its configuration
//   dram_valid                DRAM beat available
//   ifmap/weight/bias_wen     GLB write enables
//   array_ren, ofmap_ren      GLB read enables
//   data_address              GLB address
//   i_en_array, valid_array   array issue strobe / pass complete
//   compute_stage             current array pass
//   i_en_ppu, ppu_count       PPU input valid / beats issued
//   tile_idx                  current tile
//   busy, done, err           job status
// Optional build macro CTRL_PERF_CNT_EN adds stall_cycles and job_cycles.
module tiled_layer_controller
    import tiled_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LANES       = DEF_LANES,
    parameter int ARRAY_TIMES = DEF_ARRAY_TIMES,
    parameter int MAX_TILES   = DEF_MAX_TILES,
    parameter int TILE_W      = $clog2(MAX_TILES) + 1,
    parameter int ADDR_W      = $clog2(WIDTH * WIDTH / LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [TILE_W-1:0]              cfg_tiles,
    input  logic                           cfg_reuse_weight,
    input  logic                           dram_valid,
    output logic                           ifmap_wen,
    output logic                           weight_wen,
    output logic                           bias_wen,
    output logic                           array_ren,
    output logic                           ofmap_ren,
    output logic [ADDR_W-1:0]              data_address,
    output logic                           i_en_array,
    input  logic                           valid_array,
    output logic [$clog2(ARRAY_TIMES)-1:0] compute_stage,
    output logic                           i_en_ppu,
    output logic [$clog2(WIDTH):0]         ppu_count,
    output logic [TILE_W-1:0]              tile_idx,
    output logic                           busy,
    output logic                           done,
    output logic                           err
`ifdef CTRL_PERF_CNT_EN
   ,output logic [31:0]                    stall_cycles,
    output logic [31:0]                    job_cycles
`endif
);

    localparam int CS_W         = $clog2(ARRAY_TIMES);
    localparam int PPU_W        = $clog2(WIDTH) + 1;
    localparam int IFMAP_BEATS  = ifmap_beats(WIDTH, LANES);
    localparam int WEIGHT_BEATS = weight_beats(WIDTH, LANES);
    localparam int BIAS_BEATS   = bias_beats(WIDTH);
    localparam int PPU_BEATS    = ppu_beats(WIDTH);

    ctrl_state_e         state;
    logic [TILE_W-1:0]   cfg_tiles_q;
    logic                cfg_reuse_q;

    logic                in_load;
    logic                beat;
    logic                cfg_ok;
    logic                start_ok;
    logic                load_last;
    logic                array_last;
    logic                ppu_last;
    logic                state_change;

    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W-1:0]   addr_term;
    logic                addr_tc;
    logic                stage_tc;
    logic                ppu_tc;

    // Status and strobe outputs decode directly from the state register,
    // so they drop to zero the instant an asynchronous reset lands.
    assign in_load    = (state == LOAD_IFMAP) || (state == LOAD_WEIGHT) || (state == LOAD_BIAS);
    assign beat       = in_load && dram_valid;
    assign ifmap_wen  = (state == LOAD_IFMAP)  && dram_valid;
    assign weight_wen = (state == LOAD_WEIGHT) && dram_valid;
    assign bias_wen   = (state == LOAD_BIAS)   && dram_valid;
    assign array_ren  = (state == ARRAY);
    assign ofmap_ren  = (state == PPU);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // The PPU reads the GLB with one cycle of latency, so the beat issued at
    // address 0 has no data behind it yet and is held back.
    assign i_en_ppu   = (state == PPU) && (addr_cnt != '0);

    // During the array phase the GLB is indexed by the pass number; the
    // shared address counter is parked at zero then.
    assign data_address = (state == ARRAY) ? ADDR_W'(compute_stage) : addr_cnt;

    assign cfg_ok   = (cfg_tiles != '0) && (cfg_tiles <= TILE_W'(MAX_TILES));
    assign start_ok = (state == IDLE) && start && cfg_ok;

    // Last word of whichever load phase is active.
    always_comb begin
        addr_term = '0;
        case (state)
            LOAD_IFMAP:  addr_term = ADDR_W'(IFMAP_BEATS - 1);
            LOAD_WEIGHT: addr_term = ADDR_W'(WEIGHT_BEATS - 1);
            LOAD_BIAS:   addr_term = ADDR_W'(BIAS_BEATS - 1);
            default:     addr_term = '0;
        endcase
    end

    // The PPU phase ends on the edge that would carry ppu_count to
    // PPU_BEATS, so the phase lasts exactly PPU_BEATS cycles.
    assign load_last    = beat && addr_tc;
    assign array_last   = (state == ARRAY) && valid_array && stage_tc;
    assign ppu_last     = (state == PPU) && ppu_tc;
    assign state_change = start_ok || load_last || array_last || ppu_last || (state == DONE);

    beat_counter #(.W(ADDR_W)) u_addr_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (state_change),
        .load        (1'b0),
        .load_value  ('0),
        .enable      (beat || (state == PPU)),
        .terminal    (addr_term),
        .count       (addr_cnt),
        .at_terminal (addr_tc)
    );

    beat_counter #(.W(CS_W)) u_stage_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (array_last),
        .load        (1'b0),
        .load_value  ('0),
        .enable      ((state == ARRAY) && valid_array),
        .terminal    (CS_W'(ARRAY_TIMES - 1)),
        .count       (compute_stage),
        .at_terminal (stage_tc)
    );

    beat_counter #(.W(PPU_W)) u_ppu_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (ppu_last),
        .load        (1'b0),
        .load_value  ('0),
        .enable      (state == PPU),
        .terminal    (PPU_W'(PPU_BEATS - 1)),
        .count       (ppu_count),
        .at_terminal (ppu_tc)
    );

    // Main sequencer. Configuration is captured only on an accepted start
    // and ignored afterwards; tile_idx survives DONE so the last tile can be
    // inspected after the job. i_en_array and err are single-cycle pulses
    // and fall back to zero unless re-armed below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cfg_tiles_q <= '0;
            cfg_reuse_q <= 1'b0;
            tile_idx    <= '0;
            i_en_array  <= 1'b0;
            err         <= 1'b0;
        end else begin
            i_en_array <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cfg_tiles_q <= cfg_tiles;
                            cfg_reuse_q <= cfg_reuse_weight;
                            tile_idx    <= '0;
                            state       <= LOAD_IFMAP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD_IFMAP: begin
                    if (load_last) begin
                        if (cfg_reuse_q && (tile_idx != '0)) begin
                            state      <= ARRAY;
                            i_en_array <= 1'b1;
                        end else begin
                            state <= LOAD_WEIGHT;
                        end
                    end
                end
                LOAD_WEIGHT: begin
                    if (load_last) begin
                        state <= LOAD_BIAS;
                    end
                end
                LOAD_BIAS: begin
                    if (load_last) begin
                        state      <= ARRAY;
                        i_en_array <= 1'b1;
                    end
                end
                ARRAY: begin
                    if (valid_array) begin
                        if (stage_tc) begin
                            state <= PPU;
                        end else begin
                            i_en_array <= 1'b1;
                        end
                    end
                end
                PPU: begin
                    if (ppu_last) begin
                        if ((tile_idx + TILE_W'(1)) < cfg_tiles_q) begin
                            tile_idx <= tile_idx + TILE_W'(1);
                            state    <= LOAD_IFMAP;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Performance counters: restarted by each accepted job, frozen once the
    // controller is idle again, and pinned at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            job_cycles   <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
            job_cycles   <= '0;
        end else begin
            if (busy && (job_cycles != '1)) begin
                job_cycles <= job_cycles + 32'd1;
            end
            if (in_load && !dram_valid && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tiled_layer_controller.sv
// tb_tiled_layer_controller
// Scoreboard bench for tiled_layer_controller. Each job request pushes the
// full list of expected observable events (GLB writes, array issues, PPU
// beats, done, err) into a queue; an independent monitor pops and compares
// one entry for every strobe the controller raises.
module tb_tiled_layer_controller;

    localparam int WIDTH       = 64;
    localparam int LANES       = 4;
    localparam int ARRAY_TIMES = 16;
    localparam int MAX_TILES   = 16;
    localparam int TILE_W      = $clog2(MAX_TILES) + 1;
    localparam int ADDR_W      = $clog2(WIDTH * WIDTH / LANES);
    localparam int CS_W        = $clog2(ARRAY_TIMES);
    localparam int PPU_W       = $clog2(WIDTH) + 1;

    localparam int IFMAP_N  = WIDTH / LANES;
    localparam int WEIGHT_N = WIDTH * WIDTH / LANES;
    localparam int BIAS_N   = WIDTH;
    localparam int PPU_N    = WIDTH;

    localparam int EV_IFMAP  = 0;
    localparam int EV_WEIGHT = 1;
    localparam int EV_BIAS   = 2;
    localparam int EV_ARRAY  = 3;
    localparam int EV_PPU    = 4;
    localparam int EV_DONE   = 5;
    localparam int EV_ERR    = 6;

    typedef struct {
        int kind;
        int addr;
        int tile;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic              cfg_reuse_weight = 1'b0;
    logic              dram_valid = 1'b0;
    logic              valid_array = 1'b0;
    logic              ifmap_wen, weight_wen, bias_wen;
    logic              array_ren, ofmap_ren;
    logic [ADDR_W-1:0] data_address;
    logic              i_en_array;
    logic [CS_W-1:0]   compute_stage;
    logic              i_en_ppu;
    logic [PPU_W-1:0]  ppu_count;
    logic [TILE_W-1:0] tile_idx;
    logic              busy, done, err;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]       stall_cycles, job_cycles;
`endif

    ev_t exp_q[$];
    int  checks     = 0;
    int  errors     = 0;
    int  done_count = 0;
    int  ev_seq     = 0;
    int  valid_pct  = 100;
    int  held_tile  = 0;

    tiled_layer_controller #(
        .WIDTH       (WIDTH),
        .LANES       (LANES),
        .ARRAY_TIMES (ARRAY_TIMES),
        .MAX_TILES   (MAX_TILES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_tiles        (cfg_tiles),
        .cfg_reuse_weight (cfg_reuse_weight),
        .dram_valid       (dram_valid),
        .ifmap_wen        (ifmap_wen),
        .weight_wen       (weight_wen),
        .bias_wen         (bias_wen),
        .array_ren        (array_ren),
        .ofmap_ren        (ofmap_ren),
        .data_address     (data_address),
        .i_en_array       (i_en_array),
        .valid_array      (valid_array),
        .compute_stage    (compute_stage),
        .i_en_ppu         (i_en_ppu),
        .ppu_count        (ppu_count),
        .tile_idx         (tile_idx),
        .busy             (busy),
        .done             (done),
        .err              (err)
`ifdef CTRL_PERF_CNT_EN
       ,.stall_cycles     (stall_cycles),
        .job_cycles       (job_cycles)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: a job is, per tile, the ifmap words, the weight and
    // bias words unless reused from tile 0, one issue per array pass, and
    // PPU beats 1..PPU_N-1 (beat 0 is hidden by the GLB read latency),
    // followed by a single done while the last tile index is still shown.
    function automatic void modelJob(input int tiles, input bit reuse);
        for (int t = 0; t < tiles; t++) begin
            for (int a = 0; a < IFMAP_N; a++) exp_q.push_back('{EV_IFMAP, a, t});
            if (t == 0 || !reuse) begin
                for (int a = 0; a < WEIGHT_N; a++) exp_q.push_back('{EV_WEIGHT, a, t});
                for (int a = 0; a < BIAS_N; a++) exp_q.push_back('{EV_BIAS, a, t});
            end
            for (int s = 0; s < ARRAY_TIMES; s++) exp_q.push_back('{EV_ARRAY, s, t});
            for (int p = 1; p < PPU_N; p++) exp_q.push_back('{EV_PPU, p, t});
        end
        exp_q.push_back('{EV_DONE, 0, tiles - 1});
    endfunction

    // Scoreboard comparison for one observed strobe. For array issues and
    // PPU beats the pass index / beat count must track the address.
    task automatic observe(input int kind, input int addr, input int aux, input int tile);
        ev_t e;
        ev_seq++;
        if (exp_q.size() == 0) begin
            checkOutput($sformatf("ev%0d_unexpected_kind%0d", ev_seq, kind), 1, 0);
            return;
        end
        e = exp_q.pop_front();
        checkOutput($sformatf("ev%0d_kind", ev_seq), kind, e.kind);
        checkOutput($sformatf("ev%0d_addr", ev_seq), addr, e.addr);
        checkOutput($sformatf("ev%0d_tile", ev_seq), tile, e.tile);
        if (e.kind == EV_ARRAY || e.kind == EV_PPU)
            checkOutput($sformatf("ev%0d_stage_or_count", ev_seq), aux, e.addr);
    endtask

    // Monitor: sample on the falling edge and feed every strobe to the
    // scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ifmap_wen)  observe(EV_IFMAP,  int'(data_address), 0, int'(tile_idx));
                if (weight_wen) observe(EV_WEIGHT, int'(data_address), 0, int'(tile_idx));
                if (bias_wen)   observe(EV_BIAS,   int'(data_address), 0, int'(tile_idx));
                if (i_en_array) observe(EV_ARRAY,  int'(data_address), int'(compute_stage), int'(tile_idx));
                if (i_en_ppu)   observe(EV_PPU,    int'(data_address), int'(ppu_count), int'(tile_idx));
                if (err)        observe(EV_ERR,    int'(data_address), 0, int'(tile_idx));
                if (done) begin
                    observe(EV_DONE, int'(data_address), 0, int'(tile_idx));
                    done_count++;
                end
            end
        end
    end

    // DRAM model: a beat is offered each cycle with probability valid_pct.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dram_valid = ($urandom_range(0, 99) < valid_pct);
        end
    end

    // Array model: each issue completes after a random 1..4 cycle delay.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && i_en_array) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                valid_array = 1'b1;
                @(posedge clk);
                #1;
                valid_array = 1'b0;
            end
        end
    end

    // Issue one job request and record its expected effect. Config inputs
    // are scrambled right after the sampling edge to show they are latched.
    task automatic applyStimulus(input int tiles, input bit reuse, input int pct);
        valid_pct = pct;
        if (tiles >= 1 && tiles <= MAX_TILES) begin
            modelJob(tiles, reuse);
            held_tile = tiles - 1;
        end else begin
            exp_q.push_back('{EV_ERR, 0, held_tile});
        end
        @(posedge clk);
        #1;
        start            = 1'b1;
        cfg_tiles        = TILE_W'(tiles);
        cfg_reuse_weight = reuse;
        @(posedge clk);
        #1;
        start            = 1'b0;
        cfg_tiles        = TILE_W'($urandom_range(0, 31));
        cfg_reuse_weight = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDone(input string name);
        int  d0;
        bit  seen;
        d0   = done_count;
        seen = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            if (done_count != d0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        checkOutput({name, "_busy_after_done"}, int'(busy), 0);
        checkOutput({name, "_done_one_cycle"}, int'(done), 0);
        checkOutput({name, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_ifmap_wen"},     int'(ifmap_wen), 0);
        checkOutput({name, "_weight_wen"},    int'(weight_wen), 0);
        checkOutput({name, "_bias_wen"},      int'(bias_wen), 0);
        checkOutput({name, "_array_ren"},     int'(array_ren), 0);
        checkOutput({name, "_ofmap_ren"},     int'(ofmap_ren), 0);
        checkOutput({name, "_data_address"},  int'(data_address), 0);
        checkOutput({name, "_i_en_array"},    int'(i_en_array), 0);
        checkOutput({name, "_compute_stage"}, int'(compute_stage), 0);
        checkOutput({name, "_i_en_ppu"},      int'(i_en_ppu), 0);
        checkOutput({name, "_ppu_count"},     int'(ppu_count), 0);
        checkOutput({name, "_tile_idx"},      int'(tile_idx), 0);
        checkOutput({name, "_busy"},          int'(busy), 0);
        checkOutput({name, "_done"},          int'(done), 0);
        checkOutput({name, "_err"},           int'(err), 0);
    endtask

    // Illegal tile count: err one cycle after the request, nothing else.
    task automatic errorCase(input int tiles);
        applyStimulus(tiles, 1'b0, 100);
        @(negedge clk);
        checkOutput($sformatf("err_pulse_tiles%0d", tiles), int'(err), 1);
        checkOutput($sformatf("err_busy_tiles%0d", tiles), int'(busy), 0);
        @(posedge clk);
        #1;
        valid_array = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("err_cleared_tiles%0d", tiles), int'(err), 0);
        @(posedge clk);
        #1;
        valid_array = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput($sformatf("err_idle_busy_tiles%0d", tiles), int'(busy), 0);
        checkOutput($sformatf("err_scoreboard_tiles%0d", tiles), exp_q.size(), 0);
    endtask

    initial begin
        bit found;
        $display("[TB] tiled_layer_controller bench starting");

        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #3 rst = 1'b1;

        $display("[TB] single tile, continuous DRAM beats");
        applyStimulus(1, 1'b0, 100);
        waitDone("single_full");

        $display("[TB] single tile, 50%% DRAM beats");
        applyStimulus(1, 1'b0, 50);
        waitDone("single_half");

        $display("[TB] three tiles with weight reuse");
        applyStimulus(3, 1'b1, 60);
        waitDone("three_reuse");

        $display("[TB] illegal tile counts");
        errorCase(0);
        errorCase(MAX_TILES + 1);

        $display("[TB] maximum tile count with reuse");
        applyStimulus(MAX_TILES, 1'b1, 100);
        waitDone("max_tiles");

        $display("[TB] reset during array pass 7");
        applyStimulus(1, 1'b0, 100);
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (array_ren && compute_stage == CS_W'(7)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_array_stage7", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        checkAllZero("midjob_reset");
        exp_q.delete();
        held_tile = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        applyStimulus(1, 1'b0, 100);
        waitDone("after_reset");

        $display("[TB] start pulse while in PPU");
        applyStimulus(2, 1'b0, 100);
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ofmap_ren) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_ppu", int'(found), 1);
        start            = 1'b1;
        cfg_tiles        = TILE_W'(5);
        cfg_reuse_weight = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("start_in_ppu");

        $display("[TB] randomized jobs");
        for (int j = 0; j < 3; j++) begin
            applyStimulus($urandom_range(1, 2), 1'($urandom_range(0, 1)), $urandom_range(50, 100));
            waitDone($sformatf("random%0d", j));
        end

        checkOutput("final_scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiled_layer_controller.md
Name: tiled_layer_controller

Overview:
- Parametrised successor to the single-tile accelerator controller.
- Sequences one layer as N runtime-configured tiles: GLB load from DRAM (ifmap, weight, bias), systolic-array passes, then PPU drain, per tile.
- Adds a DRAM beat handshake, optional weight/bias reuse across tiles, a start/done job handshake and config-error reporting.
- Sits between the DRAM/GLB fill path and the array/PPU datapath.

Parameters:
- WIDTH, 64, vector width (elements per row).
- LANES, 4, elements per GLB word.
- ARRAY_TIMES, 16, array passes per tile.
- MAX_TILES, 16, maximum tiles per job.
- TILE_W, $clog2(MAX_TILES)+1, width of cfg_tiles.
- ADDR_W, $clog2(WIDTH*WIDTH/LANES), GLB address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_tiles  in  TILE_W  tiles in the job; latched on start.
- cfg_reuse_weight  in  1  load weight/bias for tile 0 only; latched on start.
- dram_valid  in  1  DRAM beat available this cycle.
- ifmap_wen / weight_wen / bias_wen  out  1 each  GLB write enables.
- array_ren  out  1  GLB read enable (ifmap/weight/bias) toward the array.
- ofmap_ren  out  1  GLB ofmap read enable.
- data_address  out  ADDR_W  GLB address.
- i_en_array  out  1  array issue strobe.
- valid_array  in  1  array pass complete.
- compute_stage  out  $clog2(ARRAY_TIMES)  current array pass.
- i_en_ppu  out  1  PPU input valid.
- ppu_count  out  $clog2(WIDTH)+1  PPU beats issued.
- tile_idx  out  TILE_W  current tile.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse on illegal config.

Behaviour:
- Reset (rst low, async): state IDLE; every output 0; cfg latches and counters 0.
- Beat counts: IFMAP_BEATS=WIDTH/LANES, WEIGHT_BEATS=WIDTH*WIDTH/LANES, BIAS_BEATS=WIDTH, PPU_BEATS=WIDTH.
- States: IDLE, LOAD_IFMAP, LOAD_WEIGHT, LOAD_BIAS, ARRAY, PPU, DONE.
- IDLE:
  - start with cfg_tiles in 1..MAX_TILES: latch cfg, tile_idx=0, go to LOAD_IFMAP.
  - start with cfg_tiles==0 or >MAX_TILES: err pulse next cycle, stay in IDLE.
- LOAD_x:
  - x_wen = (state==LOAD_x) && dram_valid, combinational.
  - data_address increments on each accepted beat.
  - dram_valid low: address holds, no write.
  - On the last beat: data_address returns to 0 and the FSM advances.
  - Order is IFMAP, WEIGHT, BIAS, ARRAY.
  - tile_idx>0 with reuse latched: LOAD_IFMAP goes directly to ARRAY.
- ARRAY:
  - array_ren high throughout.
  - i_en_array is a one-cycle pulse on the first ARRAY cycle and on the cycle after each valid_array with compute_stage<ARRAY_TIMES-1.
  - compute_stage increments on valid_array; data_address = compute_stage.
  - valid_array with compute_stage==ARRAY_TIMES-1: compute_stage returns to 0 and the FSM goes to PPU.
  - valid_array in any other state is ignored.
- PPU:
  - ofmap_ren high throughout; data_address increments every cycle from 0.
  - i_en_ppu = PPU && data_address!=0, covering 1-cycle GLB read latency.
  - ppu_count increments each cycle.
  - Exit when ppu_count==PPU_BEATS. If tile_idx<cfg_tiles-1: tile_idx++ and go to LOAD_IFMAP. Otherwise go to DONE.
- DONE: done pulse for one cycle, then IDLE; busy low, tile_idx held for debug.
- start while busy is ignored; cfg changes after start are ignored.
- Any change of state clears data_address to 0 on the same edge.
- Async reset mid-job: immediate return to IDLE with all outputs 0; no done or err.

Optional Feature:
- CTRL_PERF_CNT_EN defined:
  - Adds outputs stall_cycles[31:0] (LOAD cycles with dram_valid low) and job_cycles[31:0] (cycles with busy high).
  - Both clear on accepted start, saturate at all-ones, and hold after done.
- Undefined: the ports and logic are absent.

Decomposition:
- Package tiled_ctrl_pkg holds:
  - enum ctrl_state_e (3-bit).
  - Beat-count localparams as functions of WIDTH/LANES.
  - Default parameter constants.
- Sub-module beat_counter (load/clear/enable, terminal-count flag) is reused for data_address, compute_stage and ppu_count.

Test Plan:
- Single tile, no reuse, dram_valid always high, WIDTH=64: write counts 16/1024/64, 16 i_en_array pulses, i_en_ppu high 63 cycles, then done pulse; busy low next cycle.
- dram_valid toggled 50% during LOAD_WEIGHT: exactly 1024 weight_wen; addresses 0..1023 each written once, no gaps.
- cfg_tiles=3, reuse=1: weight_wen and bias_wen only in tile 0; tile_idx steps 0,1,2; one done at the end.
- start with cfg_tiles=0: err pulse, busy stays 0, no wen asserted.
- rst low during ARRAY, stage 7: all outputs 0 asynchronously; after release, a new start runs a clean full job.
- start pulsed during PPU: ignored; tile_idx and cfg unchanged; job completes normally.
